// File: rtl/battle_pkg.sv
// battle_pkg: shared types and helpers for the battle turn scheduler.
//   state_t  - state_out encodings (IDLE is deliberately non-zero so MENU entry always changes state_out)
//   cmd_t    - menu command encodings
//   HP_W     - width of every HP register
//   sat_sub  - subtraction that floors at zero
package battle_pkg;
    localparam int HP_W = 8;
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b1010,
        ST_MENU    = 4'b0000,
        ST_ATTACK  = 4'b0001,
        ST_ENEMY   = 4'b0010,
        ST_OVER    = 4'b0011,
        ST_VICTORY = 4'b0100
    } state_t;
    typedef enum logic [1:0] {CMD_ATTACK, CMD_ACT, CMD_TALK, CMD_MERCY} cmd_t;
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a, input logic [HP_W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction
endpackage

// File: rtl/battle_if.sv
// battle_if: signal bundle between the battle screen and the turn scheduler.
//   inputs to the scheduler : start_in, frame_tick_in, menu_finished_in, menu_command_in, hit_in
//   outputs from scheduler  : state_out, player_hp_out, enemy_hp_out, invincible_out, turn_count_out
//   master drives the inputs (screen/menu side), slave is the scheduler.
interface battle_if import battle_pkg::*; ();
    logic            start_in;
    logic            frame_tick_in;
    logic            menu_finished_in;
    logic [1:0]      menu_command_in;
    logic            hit_in;
    logic [3:0]      state_out;
    logic [HP_W-1:0] player_hp_out;
    logic [HP_W-1:0] enemy_hp_out;
    logic            invincible_out;
    logic [7:0]      turn_count_out;
    modport master (
        output start_in, frame_tick_in, menu_finished_in, menu_command_in, hit_in,
        input  state_out, player_hp_out, enemy_hp_out, invincible_out, turn_count_out
    );
    modport slave (
        input  start_in, frame_tick_in, menu_finished_in, menu_command_in, hit_in,
        output state_out, player_hp_out, enemy_hp_out, invincible_out, turn_count_out
    );
endinterface

// File: rtl/frame_timer.sv
// frame_timer: counts frame ticks up to a run-time limit.
//   clk, rst - clock and synchronous active-high reset
//   clr      - restarts the count at zero
//   tick     - one-cycle frame pulse
//   limit    - number of ticks per period
//   done     - high on the limit-th tick (count==limit-1 && tick)
module frame_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        tick,
    input  logic [15:0] limit,
    output logic        done
);
    logic [15:0] count;
    assign done = tick && count == limit - 16'd1;
    always_ff @(posedge clk)
        if (rst || clr) count <= '0;
        else if (tick) count <= done ? '0 : count + 16'd1;
endmodule

// File: rtl/battle_sequencer.sv
// battle_sequencer: turn scheduler for the battle screen; owns player/enemy HP, i-frames and turn count.
//   clk, rst - clock and synchronous active-high reset
//   bus      - battle_if slave: start/frame/menu/hit inputs, registered state/HP/invincible/turn outputs
module battle_sequencer import battle_pkg::*; #(
    parameter int PLAYER_HP_MAX = 20,
    parameter int ENEMY_HP_MAX  = 30,
    parameter int ATTACK_DAMAGE = 6,
    parameter int HIT_DAMAGE    = 4,
    parameter int ATTACK_FRAMES = 60,
    parameter int TURN_FRAMES   = 300,
    parameter int IFRAMES       = 30
) (
    input logic     clk,
    input logic     rst,
    battle_if.slave bus
);
    localparam logic [3:0] IDLE    = ST_IDLE;
    localparam logic [3:0] MENU    = ST_MENU;
    localparam logic [3:0] ATTACK  = ST_ATTACK;
    localparam logic [3:0] ENEMY   = ST_ENEMY;
    localparam logic [3:0] OVER    = ST_OVER;
    localparam logic [3:0] VICTORY = ST_VICTORY;
    localparam logic [HP_W-1:0] P_MAX    = HP_W'(PLAYER_HP_MAX);
    localparam logic [HP_W-1:0] E_MAX    = HP_W'(ENEMY_HP_MAX);
    localparam logic [HP_W-1:0] MERCY_HP = HP_W'(ENEMY_HP_MAX / 4);
    logic [3:0]      state, next;
    logic [HP_W-1:0] player_hp, enemy_hp, hp_after;
    logic [7:0]      turn_count;
    logic            inv, start_q, start_rise, terminal, hit_ok, phase_done, iframe_done;
    assign start_rise = bus.start_in && !start_q;
    assign terminal   = state == IDLE || state == OVER || state == VICTORY;
    assign hit_ok     = state == ENEMY && bus.hit_in && !inv;
    assign hp_after   = hit_ok ? sat_sub(player_hp, HP_W'(HIT_DAMAGE)) : player_hp;
    // Phase timer restarts on every state change; its period depends on the phase.
    frame_timer phase_timer (
        .clk(clk), .rst(rst), .clr(next != state), .tick(bus.frame_tick_in),
        .limit(state == ATTACK ? 16'(ATTACK_FRAMES) : 16'(TURN_FRAMES)), .done(phase_done)
    );
    frame_timer iframe_timer (
        .clk(clk), .rst(rst), .clr(hit_ok), .tick(bus.frame_tick_in),
        .limit(16'(IFRAMES)), .done(iframe_done)
    );
    // A hit landing on the final turn tick is resolved before choosing MENU vs GAME_OVER.
    always_comb begin
        next = state;
        if (terminal)
            next = start_rise ? MENU : state;
        else if (state == MENU && bus.menu_finished_in)
            next = bus.menu_command_in == CMD_ATTACK ? ATTACK :
                   (bus.menu_command_in == CMD_MERCY && enemy_hp <= MERCY_HP) ? VICTORY : ENEMY;
        else if (state == ATTACK && phase_done)
            next = enemy_hp == '0 ? VICTORY : ENEMY;
        else if (state == ENEMY)
            next = (player_hp == '0 || (phase_done && hp_after == '0)) ? OVER :
                   phase_done ? MENU : ENEMY;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            player_hp  <= P_MAX;
            enemy_hp   <= E_MAX;
            turn_count <= '0;
            inv        <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            start_q <= bus.start_in;
            state   <= next;
            if (terminal && start_rise) begin
                player_hp  <= P_MAX;
                enemy_hp   <= E_MAX;
                turn_count <= '0;
            end
            if (state == MENU && bus.menu_finished_in && bus.menu_command_in == CMD_ATTACK)
                enemy_hp <= sat_sub(enemy_hp, HP_W'(ATTACK_DAMAGE));
            if (hit_ok)
                player_hp <= hp_after;
            // I-frames only survive while staying in ENEMY_TURN.
            inv <= state == ENEMY && next == ENEMY && (hit_ok || (inv && !iframe_done));
            if (state == ENEMY && next == MENU && turn_count != 8'hFF)
                turn_count <= turn_count + 8'd1;
        end
    end
    assign bus.state_out      = state;
    assign bus.player_hp_out  = player_hp;
    assign bus.enemy_hp_out   = enemy_hp;
    assign bus.invincible_out = inv;
    assign bus.turn_count_out = turn_count;
endmodule

// File: tb/tb_battle_sequencer.sv
// tb_battle_sequencer: directed self-checking bench for battle_sequencer.
module tb_battle_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    battle_if bus ();
    battle_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            bus.frame_tick_in = 1'b1;
            @(negedge clk);
            bus.frame_tick_in = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic menu(input logic [1:0] cmd);
        bus.menu_command_in  = cmd;
        bus.menu_finished_in = 1'b1;
        @(negedge clk);
        bus.menu_finished_in = 1'b0;
    endtask

    task automatic hit();
        bus.hit_in = 1'b1;
        @(negedge clk);
        bus.hit_in = 1'b0;
    endtask

    task automatic start();
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic attack_turn();
        menu(2'b00);
        ticks(60);
        ticks(300);
    endtask

    initial begin
        bus.start_in = 0; bus.frame_tick_in = 0; bus.menu_finished_in = 0;
        bus.menu_command_in = 0; bus.hit_in = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", 32'(bus.state_out), 32'hA);
        chk("reset_php", 32'(bus.player_hp_out), 20);
        chk("reset_ehp", 32'(bus.enemy_hp_out), 30);
        chk("reset_inv", 32'(bus.invincible_out), 0);
        chk("reset_turns", 32'(bus.turn_count_out), 0);

        bus.start_in = 1'b1;
        @(negedge clk);
        chk("start_menu", 32'(bus.state_out), 32'h0);
        bus.start_in = 1'b0;
        @(negedge clk);
        hit();
        chk("menu_hit_ignored", 32'(bus.player_hp_out), 20);

        menu(2'b00);
        chk("attack_state", 32'(bus.state_out), 32'h1);
        chk("attack_ehp", 32'(bus.enemy_hp_out), 24);
        ticks(59);
        chk("attack_59", 32'(bus.state_out), 32'h1);
        ticks(1);
        chk("attack_60", 32'(bus.state_out), 32'h2);

        hit();
        chk("hit1_php", 32'(bus.player_hp_out), 16);
        chk("hit1_inv", 32'(bus.invincible_out), 1);
        ticks(5);
        hit();
        chk("hit2_ignored", 32'(bus.player_hp_out), 16);
        ticks(24);
        chk("inv_29", 32'(bus.invincible_out), 1);
        ticks(1);
        chk("inv_30", 32'(bus.invincible_out), 0);
        hit();
        chk("hit3_php", 32'(bus.player_hp_out), 12);
        ticks(269);
        chk("turn_299", 32'(bus.state_out), 32'h2);
        ticks(1);
        chk("turn_300", 32'(bus.state_out), 32'h0);
        chk("turn_count1", 32'(bus.turn_count_out), 1);

        attack_turn();
        attack_turn();
        chk("ehp_12", 32'(bus.enemy_hp_out), 12);
        chk("turn_count3", 32'(bus.turn_count_out), 3);
        menu(2'b11);
        chk("mercy_12_state", 32'(bus.state_out), 32'h2);
        chk("mercy_12_ehp", 32'(bus.enemy_hp_out), 12);
        ticks(300);
        attack_turn();
        chk("ehp_6", 32'(bus.enemy_hp_out), 6);
        menu(2'b11);
        chk("mercy_6_state", 32'(bus.state_out), 32'h4);
        menu(2'b00);
        chk("victory_menu_ignored", 32'(bus.state_out), 32'h4);
        chk("victory_ehp_kept", 32'(bus.enemy_hp_out), 6);

        bus.start_in = 1'b1;
        @(negedge clk);
        chk("restart_state", 32'(bus.state_out), 32'h0);
        chk("restart_php", 32'(bus.player_hp_out), 20);
        chk("restart_ehp", 32'(bus.enemy_hp_out), 30);
        chk("restart_turns", 32'(bus.turn_count_out), 0);
        bus.start_in = 1'b0;
        @(negedge clk);
        start();
        chk("menu_start_ignored", 32'(bus.state_out), 32'h0);

        repeat (4) attack_turn();
        menu(2'b00);
        chk("fifth_attack_ehp", 32'(bus.enemy_hp_out), 0);
        chk("fifth_attack_state", 32'(bus.state_out), 32'h1);
        ticks(59);
        chk("kill_59", 32'(bus.state_out), 32'h1);
        ticks(1);
        chk("kill_victory", 32'(bus.state_out), 32'h4);

        start();
        chk("start3_state", 32'(bus.state_out), 32'h0);
        menu(2'b01);
        chk("act_state", 32'(bus.state_out), 32'h2);
        repeat (4) begin
            hit();
            ticks(30);
        end
        chk("php_4", 32'(bus.player_hp_out), 4);
        ticks(179);
        bus.hit_in = 1'b1;
        bus.frame_tick_in = 1'b1;
        @(negedge clk);
        bus.hit_in = 1'b0;
        bus.frame_tick_in = 1'b0;
        chk("final_hit_php", 32'(bus.player_hp_out), 0);
        chk("final_hit_state", 32'(bus.state_out), 32'h3);

        start();
        menu(2'b10);
        chk("talk_state", 32'(bus.state_out), 32'h2);
        ticks(10);
        hit();
        chk("pre_rst_php", 32'(bus.player_hp_out), 16);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_state", 32'(bus.state_out), 32'hA);
        chk("rst_php", 32'(bus.player_hp_out), 20);
        chk("rst_ehp", 32'(bus.enemy_hp_out), 30);
        chk("rst_inv", 32'(bus.invincible_out), 0);
        @(negedge clk);
        chk("rst_idle_hold", 32'(bus.state_out), 32'hA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
